axi_lite_master: RTL

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

---
 rtl/axi_lite_master.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_master.sv
// AXI4-Lite master that carries one local command at a time onto the AXI4-Lite
// read or write channels and returns a single response, with an optional timeout.
module axi_lite_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic        cmd_valid,
    output logic        CMD_READY,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,

    output logic        RSP_VALID,
    input  logic        rsp_ready,
    output logic [31:0] RSP_DATA,
    output logic [1:0]  RSP_RESP,
    output logic        RSP_TIMEOUT,

    output logic [31:0] AW_ADDR,
    output logic        AW_VALID,
    input  logic        aw_ready,
    output logic [31:0] W_DATA,
    output logic [3:0]  W_STRB,
    output logic        W_VALID,
    input  logic        w_ready,
    input  logic [1:0]  b_resp,
    input  logic        b_valid,
    output logic        B_READY,
    output logic [31:0] AR_ADDR,
    output logic        AR_VALID,
    input  logic        ar_ready,
    input  logic [31:0] r_data,
    input  logic [1:0]  r_resp,
    input  logic        r_valid,
    output logic        R_READY
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RESP    = 3'd5
    } state_e;

    state_e      state_q;
    logic        cmd_ready_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_valid_q;
    logic        w_valid_q;
    logic        b_ready_q;
    logic        ar_valid_q;
    logic        r_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic [1:0]  rsp_resp_q;
    logic        rsp_timeout_q;
    logic [31:0] cnt_q;

    logic        aw_hs;
    logic        w_hs;
    logic        b_hs;
    logic        ar_hs;
    logic        r_hs;
    logic        wr_req_done;
    logic        busy;
    logic        complete;
    logic        timeout_hit;
    logic        abort;
    logic [31:0] cnt_d;

    // NOTE: every variable gets a value on every path through always_comb, so no latch is inferred.
    always_comb begin
        aw_hs       = aw_valid_q && aw_ready;
        w_hs        = w_valid_q && w_ready;
        b_hs        = b_ready_q && b_valid;
        ar_hs       = ar_valid_q && ar_ready;
        r_hs        = r_ready_q && r_valid;
        // A write channel is finished once its VALID has dropped or it handshakes now.
        wr_req_done = (!aw_valid_q || aw_hs) && (!w_valid_q || w_hs);
        busy        = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                      (state_q == RD_REQ) || (state_q == RD_DATA);
        complete    = b_hs || r_hs;
        // cnt_d counts busy cycles including the current one; the budget is spent when it hits the limit.
        cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
        timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (cnt_d >= TIMEOUT_CYCLES);
        abort       = busy && !complete && timeout_hit;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b1;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            aw_valid_q    <= 1'b0;
            w_valid_q     <= 1'b0;
            b_ready_q     <= 1'b0;
            ar_valid_q    <= 1'b0;
            r_ready_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        cnt_q       <= '0;
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        wstrb_q     <= cmd_wstrb;
                        if (cmd_write) begin
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                            state_q    <= WR_REQ;
                        end else begin
                            ar_valid_q <= 1'b1;
                            state_q    <= RD_REQ;
                        end
                    end
                end

                WR_REQ: begin
                    if (aw_hs) begin
                        aw_valid_q <= 1'b0;
                    end
                    if (w_hs) begin
                        w_valid_q <= 1'b0;
                    end
                    if (wr_req_done) begin
                        b_ready_q <= 1'b1;
                        state_q   <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (b_hs) begin
                        b_ready_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_data_q    <= '0;
                        rsp_resp_q    <= b_resp;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= RESP;
                    end
                end

                RD_REQ: begin
                    if (ar_hs) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state_q    <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (r_hs) begin
                        r_ready_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_data_q    <= r_data;
                        rsp_resp_q    <= r_resp;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= RESP;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase

            if (busy) begin
                cnt_q <= cnt_d;
            end

            // Abort overrides whatever the state arm scheduled for this edge.
            if (abort) begin
                aw_valid_q    <= 1'b0;
                w_valid_q     <= 1'b0;
                b_ready_q     <= 1'b0;
                ar_valid_q    <= 1'b0;
                r_ready_q     <= 1'b0;
                rsp_valid_q   <= 1'b1;
                rsp_data_q    <= '0;
                rsp_resp_q    <= 2'b10;
                rsp_timeout_q <= 1'b1;
                state_q       <= RESP;
            end
        end
    end

    assign CMD_READY   = cmd_ready_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_DATA    = rsp_data_q;
    assign RSP_RESP    = rsp_resp_q;
    assign RSP_TIMEOUT = rsp_timeout_q;
    assign AW_ADDR     = addr_q;
    assign AW_VALID    = aw_valid_q;
    assign W_DATA      = wdata_q;
    assign W_STRB      = wstrb_q;
    assign W_VALID     = w_valid_q;
    assign B_READY     = b_ready_q;
    assign AR_ADDR     = addr_q;
    assign AR_VALID    = ar_valid_q;
    assign R_READY     = r_ready_q;

endmodule
